// File: rtl/wr_txn_guard_mc.sv
// wr_txn_guard_mc: passive AXI write-path monitor with per-entry phase tracking,
// budget timeouts, first-error capture and sticky interrupt / reset request.
module wr_txn_guard_mc #(
   parameter int MaxWrTxns = 8,
   parameter int IdWidth   = 4,
   parameter int LenWidth  = 8,
   parameter int CntWidth  = 10
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        aw_valid_i,
   input  logic                        aw_ready_i,
   input  logic [IdWidth-1:0]          aw_id_i,
   input  logic [LenWidth-1:0]         aw_len_i,
   input  logic                        w_valid_i,
   input  logic                        w_ready_i,
   input  logic                        w_last_i,
   input  logic                        b_valid_i,
   input  logic                        b_ready_i,
   input  logic [IdWidth-1:0]          b_id_i,
   input  logic [CntWidth-1:0]         budget_aw_i,
   input  logic [CntWidth-1:0]         budget_w_i,
   input  logic [CntWidth-1:0]         budget_b_i,
   input  logic [CntWidth-1:0]         budget_brdy_i,
   input  logic                        rst_en_i,
   input  logic                        clear_i,
   output logic                        irq_o,
   output logic                        reset_req_o,
   output logic [2:0]                  err_code_o,
   output logic [IdWidth-1:0]          err_id_o,
   output logic [$clog2(MaxWrTxns):0]  outstanding_o
);
   localparam int PW = $clog2(MaxWrTxns);
   localparam int LW = CntWidth + LenWidth + 1;
   typedef enum logic [1:0] {FREE, WAIT_W, WAIT_B, WAIT_BRDY} st_e;
   st_e                 st   [MaxWrTxns];
   logic [IdWidth-1:0]  ids  [MaxWrTxns];
   logic [LenWidth-1:0] lens [MaxWrTxns];
   logic [CntWidth-1:0] cnt  [MaxWrTxns];
   logic [CntWidth-1:0] aw_cnt;
   logic [PW-1:0]       a_ptr, w_ptr, b_sel, idx;
   logic                irq, rreq;
   logic [2:0]          code, n_code;
   logic [IdWidth-1:0]  eid, n_id, b_eid, r_eid;
   logic [PW:0]         outs;
   logic [LW-1:0]       w_lim;
   logic aw_hs, w_hs, b_hs, alloc, ovf, w_act, w_done, stray, b_hit, unm, free_b;
   logic e_aw, e_w, e_b, e_brdy;
   function automatic logic [CntWidth-1:0] inc(input logic [CntWidth-1:0] c);
      return c + CntWidth'(c != '1);
   endfunction
   always_comb begin
      aw_hs  = aw_valid_i && aw_ready_i;
      w_hs   = w_valid_i && w_ready_i;
      b_hs   = b_valid_i && b_ready_i;
      alloc  = aw_hs && st[a_ptr] == FREE;
      ovf    = aw_hs && st[a_ptr] != FREE;
      w_act  = st[w_ptr] == WAIT_W;
      w_done = w_hs && w_last_i && w_act;
      stray  = w_hs && !w_act;
      w_lim  = LW'(budget_w_i) * (LW'(lens[w_ptr]) + LW'(1));
      e_aw   = budget_aw_i != '0 && aw_cnt >= budget_aw_i;
      e_w    = w_act && budget_w_i != '0 && LW'(cnt[w_ptr]) >= w_lim;
      b_hit  = 1'b0;
      b_sel  = '0;
      idx    = '0;
      // oldest-first: scan circularly starting at the allocation pointer
      for (int k = 0; k < MaxWrTxns; k++) begin
         idx = a_ptr + PW'(k);
         if (b_valid_i && !b_hit && (st[idx] == WAIT_B || st[idx] == WAIT_BRDY) && ids[idx] == b_id_i) begin
            b_hit = 1'b1;
            b_sel = idx;
         end
      end
      free_b = b_hs && b_hit;
      unm    = b_hs && !b_hit;
      e_b    = 1'b0;
      e_brdy = 1'b0;
      b_eid  = '0;
      r_eid  = '0;
      for (int i = MaxWrTxns - 1; i >= 0; i--) begin
         if (st[i] == WAIT_B && budget_b_i != '0 && cnt[i] >= budget_b_i) begin
            e_b   = 1'b1;
            b_eid = ids[i];
         end
         if (st[i] == WAIT_BRDY && budget_brdy_i != '0 && cnt[i] >= budget_brdy_i) begin
            e_brdy = 1'b1;
            r_eid  = ids[i];
         end
      end
      n_code = e_aw ? 3'd1 : e_w ? 3'd2 : e_b ? 3'd3 : e_brdy ? 3'd4 :
               ovf ? 3'd5 : stray ? 3'd6 : unm ? 3'd7 : 3'd0;
      n_id   = e_aw ? '0 : e_w ? ids[w_ptr] : e_b ? b_eid : e_brdy ? r_eid :
               ovf ? aw_id_i : stray ? '0 : b_id_i;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < MaxWrTxns; i++) begin
            st[i]   <= FREE;
            ids[i]  <= '0;
            lens[i] <= '0;
            cnt[i]  <= '0;
         end
         {aw_cnt, a_ptr, w_ptr, irq, rreq, code, eid, outs} <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < MaxWrTxns; i++) begin
            st[i]   <= FREE;
            ids[i]  <= '0;
            lens[i] <= '0;
            cnt[i]  <= '0;
         end
         {aw_cnt, a_ptr, w_ptr, irq, rreq, code, eid, outs} <= '0;
      end else begin
         for (int i = 0; i < MaxWrTxns; i++) begin
            if (st[i] == FREE) begin
               if (alloc && a_ptr == PW'(i)) begin
                  st[i]   <= WAIT_W;
                  ids[i]  <= aw_id_i;
                  lens[i] <= aw_len_i;
                  cnt[i]  <= '0;
               end
            end else if (st[i] == WAIT_W) begin
               if (w_ptr == PW'(i)) begin
                  st[i]  <= w_done ? WAIT_B : WAIT_W;
                  cnt[i] <= w_done ? '0 : inc(cnt[i]);
               end
            end else if (st[i] == WAIT_B) begin
               if (b_hit && b_sel == PW'(i)) begin
                  st[i]  <= b_ready_i ? FREE : WAIT_BRDY;
                  cnt[i] <= '0;
               end else cnt[i] <= inc(cnt[i]);
            end else begin
               if (free_b && b_sel == PW'(i)) begin
                  st[i]  <= FREE;
                  cnt[i] <= '0;
               end else if (!b_ready_i) cnt[i] <= inc(cnt[i]);
            end
         end
         aw_cnt <= (aw_valid_i && !aw_ready_i) ? inc(aw_cnt) : '0;
         a_ptr  <= a_ptr + PW'(alloc);
         w_ptr  <= w_ptr + PW'(w_done);
         outs   <= outs + (PW+1)'(alloc) - (PW+1)'(free_b);
         if (!irq && n_code != 3'd0) begin
            irq  <= 1'b1;
            rreq <= rst_en_i;
            code <= n_code;
            eid  <= n_id;
         end
      end
   end
   assign irq_o         = irq;
   assign reset_req_o   = rreq;
   assign err_code_o    = code;
   assign err_id_o      = eid;
   assign outstanding_o = outs;
endmodule

// File: tb/tb_wr_txn_guard_mc.sv
// tb_wr_txn_guard_mc: directed bench; expectations are queued with each stimulus
// step and popped against the DUT outputs once the step has been clocked.
module tb_wr_txn_guard_mc;
   localparam int N = 8, IW = 4, LW = 8, CW = 10;
   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          aw_valid_i, aw_ready_i, w_valid_i, w_ready_i, w_last_i;
   logic          b_valid_i, b_ready_i, rst_en_i, clear_i;
   logic [IW-1:0] aw_id_i, b_id_i;
   logic [LW-1:0] aw_len_i;
   logic [CW-1:0] budget_aw_i, budget_w_i, budget_b_i, budget_brdy_i;
   logic          irq_o, reset_req_o;
   logic [2:0]    err_code_o;
   logic [IW-1:0] err_id_o;
   logic [$clog2(N):0] outstanding_o;
   typedef struct {string tag; int val;} exp_t;
   exp_t sbq[$];
   int checks = 0, errors = 0;

   always #5 clk_i = ~clk_i;

   wr_txn_guard_mc #(.MaxWrTxns(N), .IdWidth(IW), .LenWidth(LW), .CntWidth(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_id_i(aw_id_i), .aw_len_i(aw_len_i),
      .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_last_i(w_last_i),
      .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_id_i(b_id_i),
      .budget_aw_i(budget_aw_i), .budget_w_i(budget_w_i), .budget_b_i(budget_b_i),
      .budget_brdy_i(budget_brdy_i), .rst_en_i(rst_en_i), .clear_i(clear_i),
      .irq_o(irq_o), .reset_req_o(reset_req_o), .err_code_o(err_code_o),
      .err_id_o(err_id_o), .outstanding_o(outstanding_o)
   );

   task automatic push(input string tag, input int val);
      sbq.push_back('{tag, val});
   endtask

   function automatic int obs(input string tag);
      if (tag == "irq")  return int'(irq_o);
      if (tag == "rreq") return int'(reset_req_o);
      if (tag == "code") return int'(err_code_o);
      if (tag == "eid")  return int'(err_id_o);
      return int'(outstanding_o);
   endfunction

   task automatic verify();
      while (sbq.size() > 0) begin
         exp_t e = sbq.pop_front();
         int got = obs(e.tag);
         checks++;
         assert (got === e.val) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, got, e.val);
         end
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         @(negedge clk_i);
      end
   endtask

   task automatic aw(input int id, input int len);
      aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = IW'(id); aw_len_i = LW'(len);
      step();
      aw_valid_i = 1'b0; aw_ready_i = 1'b0;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
   endtask

   initial begin
      {aw_valid_i, aw_ready_i, w_valid_i, w_ready_i, w_last_i, b_valid_i, b_ready_i} = '0;
      {aw_id_i, b_id_i, aw_len_i, rst_en_i, clear_i} = '0;
      budget_aw_i = 4; budget_w_i = 2; budget_b_i = 8; budget_brdy_i = 4;
      rst_ni = 1'b0;
      step(2);
      push("irq", 0); push("rreq", 0); push("code", 0); push("eid", 0); push("outs", 0);
      verify();
      rst_ni = 1'b1;
      // clean write: 4 beats, B after 5 idle cycles
      aw(3, 3);
      push("outs", 1); verify();
      w_valid_i = 1'b1; w_ready_i = 1'b1;
      step(3);
      w_last_i = 1'b1;
      step();
      {w_valid_i, w_ready_i, w_last_i} = '0;
      push("outs", 1); push("irq", 0); verify();
      step(5);
      b_valid_i = 1'b1; b_id_i = 3;
      step();
      b_ready_i = 1'b1;
      step();
      b_valid_i = 1'b0; b_ready_i = 1'b0;
      push("outs", 0); push("irq", 0); push("code", 0); verify();
      // AW timeout with reset request, then clear
      rst_en_i = 1'b1;
      aw_valid_i = 1'b1; aw_id_i = 1;
      step(4);
      push("irq", 0); verify();
      step();
      push("irq", 1); push("code", 1); push("rreq", 1); push("eid", 0); verify();
      aw_valid_i = 1'b0;
      do_clear();
      push("irq", 0); push("code", 0); push("rreq", 0); push("outs", 0); push("eid", 0); verify();
      // W budget scaled by burst length: 3*(1+1)=6
      rst_en_i = 1'b0; budget_w_i = 3;
      aw(9, 1);
      step(6);
      push("irq", 0); verify();
      step();
      push("irq", 1); push("code", 2); push("eid", 9); push("rreq", 0); push("outs", 1); verify();
      do_clear();
      // overflow on the ninth AW
      budget_w_i = 0;
      for (int i = 0; i < N; i++) aw(i, 0);
      push("outs", N); push("irq", 0); verify();
      aw(10, 0);
      push("irq", 1); push("code", 5); push("eid", 10); push("outs", N); verify();
      do_clear();
      // oldest matching entry selected first, then unmatched B
      budget_aw_i = 0; budget_b_i = 0; budget_brdy_i = 0;
      aw(5, 0);
      aw(5, 0);
      {w_valid_i, w_ready_i, w_last_i} = '1;
      step(2);
      {w_valid_i, w_ready_i, w_last_i} = '0;
      b_valid_i = 1'b1; b_id_i = 5;
      step();
      b_ready_i = 1'b1;
      step();
      b_valid_i = 1'b0; b_ready_i = 1'b0;
      push("outs", 1); push("irq", 0); verify();
      budget_b_i = 3;
      step();
      push("irq", 0); verify();
      budget_b_i = 0;
      b_valid_i = 1'b1; b_ready_i = 1'b1; b_id_i = 7;
      step();
      b_valid_i = 1'b0; b_ready_i = 1'b0;
      push("irq", 1); push("code", 7); push("eid", 7); push("outs", 1); verify();
      do_clear();
      // B-ready timeout beats a simultaneous stray W
      rst_en_i = 1'b1; budget_brdy_i = 2;
      aw(2, 0);
      {w_valid_i, w_ready_i, w_last_i} = '1;
      step();
      {w_valid_i, w_ready_i, w_last_i} = '0;
      b_valid_i = 1'b1; b_id_i = 2;
      step(3);
      push("irq", 0); verify();
      w_valid_i = 1'b1; w_ready_i = 1'b1;
      step();
      w_valid_i = 1'b0; w_ready_i = 1'b0; b_valid_i = 1'b0;
      push("irq", 1); push("code", 4); push("eid", 2); push("rreq", 1); verify();
      do_clear();
      // stray W alone
      rst_en_i = 1'b0;
      w_valid_i = 1'b1; w_ready_i = 1'b1;
      step();
      w_valid_i = 1'b0; w_ready_i = 1'b0;
      push("irq", 1); push("code", 6); push("eid", 0); push("rreq", 0); verify();
      // handshake in the clear cycle is dropped
      aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = 4;
      do_clear();
      aw_valid_i = 1'b0; aw_ready_i = 1'b0;
      push("outs", 0); push("code", 0); push("irq", 0); verify();
      // asynchronous reset mid-transaction
      aw(1, 0);
      push("outs", 1); verify();
      #2 rst_ni = 1'b0;
      #1 push("outs", 0); push("irq", 0); push("code", 0); verify();
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wr_txn_guard_mc.md
Name: wr_txn_guard_mc

Overview:
- Parametrised next-generation AXI write-path timeout monitor. Sits passively between one master and one slave and observes the AW, W and B handshakes.
- Tracks up to MaxWrTxns outstanding writes, each carrying its own phase state and budget counter.
- On a budget violation, protocol anomaly or overflow it records the first error, raises a sticky interrupt and, if enabled, a reset request.
- Over the previous single-active-W guard it adds: per-entry counters, burst-length-scaled W budget, B-ready phase, error capture, selectable reset mode and flush-on-clear.

Parameters:
MaxWrTxns, 8, outstanding-entry capacity, power of two, >=2
IdWidth, 4, AXI ID width
LenWidth, 8, AXI awlen width
CntWidth, 10, budget and counter width; counters saturate at all-ones

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
aw_valid_i  in  1  observed AW valid
aw_ready_i  in  1  observed AW ready
aw_id_i  in  IdWidth  AW ID
aw_len_i  in  LenWidth  AW burst length minus 1
w_valid_i  in  1  observed W valid
w_ready_i  in  1  observed W ready
w_last_i  in  1  observed W last
b_valid_i  in  1  observed B valid
b_ready_i  in  1  observed B ready
b_id_i  in  IdWidth  B ID
budget_aw_i  in  CntWidth  AW valid->ready budget; 0 disables
budget_w_i  in  CntWidth  per-beat W budget; 0 disables
budget_b_i  in  CntWidth  W last->B valid budget; 0 disables
budget_brdy_i  in  CntWidth  B valid->ready budget; 0 disables
rst_en_i  in  1  1: timeout also raises reset_req_o
clear_i  in  1  synchronous clear of error state and flush of all entries
irq_o  out  1  sticky error interrupt
reset_req_o  out  1  sticky reset request
err_code_o  out  3  0 none, 1 AW, 2 W, 3 B, 4 BRDY, 5 OVERFLOW, 6 STRAY_W, 7 UNMATCHED_B
err_id_o  out  IdWidth  ID of the first offending entry (0 for AW/STRAY_W)
outstanding_o  out  $clog2(MaxWrTxns)+1  count of non-FREE entries

Behaviour:
- Reset: all entries FREE; all counters 0; alloc and W pointers 0; irq_o, reset_req_o, err_code_o, err_id_o and outstanding_o all 0.
- AW counter: increments each cycle aw_valid_i && !aw_ready_i. Cleared on the handshake or when aw_valid_i drops.
- Entry states: FREE -> WAIT_W (on AW handshake) -> WAIT_B (on W last handshake) -> WAIT_BRDY (on b_valid_i matching the entry) -> FREE (on B handshake).
- AW handshake:
  - Allocates the entry at the alloc pointer, stores ID and len, clears its counter, and advances the pointer modulo MaxWrTxns.
  - If that entry is not FREE (table full): no allocation, error OVERFLOW.
- W handling:
  - W data is in AW order. The W pointer always names the oldest WAIT_W entry.
  - Only that entry's counter runs in WAIT_W, incrementing every cycle.
  - Its limit is budget_w_i*(len+1), computed CntWidth+LenWidth+1 wide with no truncation.
  - A W last handshake moves the entry to WAIT_B, clears its counter and advances the W pointer.
  - A W handshake while no WAIT_W entry exists: error STRAY_W. W-before-AW is unsupported.
- B handling:
  - In WAIT_B, the counter increments every cycle; limit budget_b_i.
  - b_valid_i selects the oldest WAIT_B or WAIT_BRDY entry whose ID equals b_id_i. Oldest means the first found scanning from the alloc pointer circularly.
  - A WAIT_B entry selected this way moves to WAIT_BRDY, counter cleared.
  - In WAIT_BRDY, the counter increments while !b_ready_i; limit budget_brdy_i. Handshake frees the entry.
  - b_valid_i with no matching entry: error UNMATCHED_B, raised once per B handshake.
- Timeout: counter >= limit with limit != 0, evaluated on the registered counter. Error is flagged the same cycle; irq_o is asserted the next cycle.
- Priority of simultaneous errors: lowest code wins. Among entries, the lowest index wins.
- Error capture: only the first error is latched into err_code_o and err_id_o. Later errors are ignored until clear.
- Sticky flags: irq_o stays high until clear_i. reset_req_o = irq_o && rst_en_i as sampled at the error, then sticky.
- Same-cycle events:
  - AW allocate, W last, B match and B handshake on different entries all take effect in the same cycle.
  - A single W beat that is also last on a just-allocated entry is not possible in the same cycle: allocation is visible next cycle, so that beat is STRAY_W.
  - outstanding_o = (#allocations) - (#frees) per cycle, registered.
- Counters saturate at all-ones and never wrap.
- clear_i has priority over every event in that cycle:
  - next cycle, all outputs and state equal the reset values;
  - handshakes seen in the clear cycle are dropped.
- Asynchronous reset mid-transaction discards all entries with no error.

Test Plan:
- AW id=3 len=3, W 4 beats with ready each cycle, B id=3 after 5 cycles, budgets aw=4 w=2 b=8 brdy=4 -> no error, outstanding_o 1->0, irq_o=0.
- aw_valid_i held 5 cycles without ready, budget_aw=4 -> err_code_o=1, irq_o high one cycle after counter reaches 4; rst_en_i=1 -> reset_req_o=1; clear_i -> all 0 next cycle.
- AW len=1, budget_w=3; w_ready_i withheld -> timeout when counter reaches 6, err_code_o=2, err_id_o=AW id.
- MaxWrTxns+1 AWs with no W -> last AW gives err_code_o=5, outstanding_o=MaxWrTxns.
- Two AWs id=5 complete W; B id=5 -> older entry freed first; B id=7 -> err_code_o=7.
- b_valid_i matched, b_ready_i low for budget_brdy_i=2 cycles -> err_code_o=4; simultaneous W stray in the same cycle -> err_code_o=4 (lower code wins).
